// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared types and sizing for the UID tag allocator
package rob_pkg;

  localparam int ID_WIDTH  = 4;
  localparam int NUM_UIDS  = 2 ** ID_WIDTH;
  localparam int CNT_WIDTH = $clog2(NUM_UIDS + 1);

  typedef logic [ID_WIDTH-1:0] uid_t;

  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } req_e;

  // UIDs are as wide as original IDs, so a pool smaller than 2**ID_WIDTH
  // leaves encodings that must be rejected on release.
  function automatic logic uid_in_range(input uid_t u);
    return int'(u) < NUM_UIDS;
  endfunction

endpackage

// File: rtl/uid_tag_allocator_if.sv
// rtl/uid_tag_allocator_if.sv - allocation, release, lookup and status signals of the UID pool
interface uid_tag_allocator_if;
  import rob_pkg::*;

  logic                 rd_alloc_req;
  uid_t                 rd_alloc_in_id;
  logic                 rd_alloc_gnt;
  uid_t                 rd_unique_id;
  logic                 wr_alloc_req;
  uid_t                 wr_alloc_in_id;
  logic                 wr_alloc_gnt;
  uid_t                 wr_unique_id;

  logic                 rd_rel_valid;
  uid_t                 rd_rel_uid;
  logic                 wr_rel_valid;
  uid_t                 wr_rel_uid;

  uid_t                 rd_lookup_uid;
  uid_t                 rd_lookup_id;
  uid_t                 wr_lookup_uid;
  uid_t                 wr_lookup_id;

  logic                 tag_map_full;
  logic [CNT_WIDTH-1:0] free_count;
  logic                 rel_err;

  modport slave (
    input  rd_alloc_req, rd_alloc_in_id, wr_alloc_req, wr_alloc_in_id,
    input  rd_rel_valid, rd_rel_uid, wr_rel_valid, wr_rel_uid,
    input  rd_lookup_uid, wr_lookup_uid,
    output rd_alloc_gnt, rd_unique_id, wr_alloc_gnt, wr_unique_id,
    output rd_lookup_id, wr_lookup_id,
    output tag_map_full, free_count, rel_err
  );

  modport master (
    output rd_alloc_req, rd_alloc_in_id, wr_alloc_req, wr_alloc_in_id,
    output rd_rel_valid, rd_rel_uid, wr_rel_valid, wr_rel_uid,
    output rd_lookup_uid, wr_lookup_uid,
    input  rd_alloc_gnt, rd_unique_id, wr_alloc_gnt, wr_unique_id,
    input  rd_lookup_id, wr_lookup_id,
    input  tag_map_full, free_count, rel_err
  );

endinterface

// File: rtl/uid_free_pick.sv
// rtl/uid_free_pick.sv - lowest-index clear bit finder over the used bitmap
module uid_free_pick #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] used,
  output logic         found,
  output logic [W-1:0] index
);

  // Scan from the top so the last hit, the lowest index, wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!used[i]) begin
        found = 1'b1;
        index = W'(i);
      end
    end
  end

endmodule

// File: rtl/uid_tag_allocator.sv
// rtl/uid_tag_allocator.sv - shared UID pool for the AR/AW ordering units
// Round-robin single grant per cycle, release from R-last/B, original-ID lookup.
module uid_tag_allocator
  import rob_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  uid_tag_allocator_if.slave  bus
);

  logic [NUM_UIDS-1:0]  used;
  uid_t                 id_table [NUM_UIDS];
  logic [CNT_WIDTH-1:0] free_count;
  logic                 full;
  req_e                 rr_ptr;
  logic                 rel_err;

  logic                 pick_found;
  uid_t                 sel_uid;

  uid_free_pick #(
    .N (NUM_UIDS),
    .W (ID_WIDTH)
  ) u_pick (
    .used  (used),
    .found (pick_found),
    .index (sel_uid)
  );

  logic can_grant;
  logic gnt_rd;
  logic gnt_wr;
  logic grant;

  // rst gates the combinational grant so nothing leaks out during reset.
  assign can_grant = !rst && pick_found && (free_count != '0) && !full;
  assign gnt_rd    = can_grant && bus.rd_alloc_req && (!bus.wr_alloc_req || rr_ptr == REQ_RD);
  assign gnt_wr    = can_grant && bus.wr_alloc_req && (!bus.rd_alloc_req || rr_ptr == REQ_WR);
  assign grant     = gnt_rd || gnt_wr;

  logic rd_ok;
  logic wr_ok;
  logic rel_bad;

  // A same-UID double release frees once; the write side is the one flagged.
  assign rd_ok   = bus.rd_rel_valid && uid_in_range(bus.rd_rel_uid) && used[bus.rd_rel_uid];
  assign wr_ok   = bus.wr_rel_valid && uid_in_range(bus.wr_rel_uid) && used[bus.wr_rel_uid]
                   && !(rd_ok && bus.rd_rel_uid == bus.wr_rel_uid);
  assign rel_bad = (bus.rd_rel_valid && !rd_ok) || (bus.wr_rel_valid && !wr_ok);

  logic [NUM_UIDS-1:0]  used_next;
  logic [CNT_WIDTH-1:0] count_next;

  always_comb begin
    used_next = used;
    if (rd_ok) used_next[bus.rd_rel_uid] = 1'b0;
    if (wr_ok) used_next[bus.wr_rel_uid] = 1'b0;
    if (grant) used_next[sel_uid] = 1'b1;
  end

  assign count_next = free_count + CNT_WIDTH'(rd_ok) + CNT_WIDTH'(wr_ok) - CNT_WIDTH'(grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      used       <= '0;
      free_count <= CNT_WIDTH'(NUM_UIDS);
      full       <= 1'b0;
      rr_ptr     <= REQ_RD;
      rel_err    <= 1'b0;
      for (int i = 0; i < NUM_UIDS; i++) id_table[i] <= '0;
    end else begin
      used       <= used_next;
      free_count <= count_next;
      full       <= (count_next == '0);
      if (rel_bad) rel_err <= 1'b1;
      if (grant) begin
        id_table[sel_uid] <= gnt_rd ? bus.rd_alloc_in_id : bus.wr_alloc_in_id;
        rr_ptr            <= gnt_rd ? REQ_WR : REQ_RD;
      end
    end
  end

  assign bus.rd_alloc_gnt = gnt_rd;
  assign bus.wr_alloc_gnt = gnt_wr;
  assign bus.rd_unique_id = sel_uid;
  assign bus.wr_unique_id = sel_uid;
  assign bus.rd_lookup_id = id_table[bus.rd_lookup_uid];
  assign bus.wr_lookup_id = id_table[bus.wr_lookup_uid];
  assign bus.tag_map_full = full;
  assign bus.free_count   = free_count;
  assign bus.rel_err      = rel_err;

endmodule

// File: tb/tb_uid_tag_allocator.sv
// tb/tb_uid_tag_allocator.sv - scoreboard bench for uid_tag_allocator
module tb_uid_tag_allocator;
  import rob_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uid_tag_allocator_if u_if ();

  uid_tag_allocator u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] exp_q [$];   // {side, uid} in expected grant order

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every grant pops the next expectation.
  always @(negedge clk) begin
    if (!rst && (u_if.rd_alloc_gnt || u_if.wr_alloc_gnt)) begin
      if (u_if.rd_alloc_gnt && u_if.wr_alloc_gnt)
        chk("dual_gnt", 32'd1, 32'd0);
      else if (exp_q.size() == 0)
        chk("unexpected_gnt", {27'd0, u_if.wr_alloc_gnt, u_if.rd_unique_id}, 32'hFFFF_FFFF);
      else
        chk("sb_grant", {27'd0, u_if.wr_alloc_gnt,
                         u_if.wr_alloc_gnt ? u_if.wr_unique_id : u_if.rd_unique_id},
            {27'd0, exp_q.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic side, input uid_t id, input uid_t exp_uid, output int waited);
    bit done;
    exp_q.push_back({side, exp_uid});
    if (side) begin u_if.wr_alloc_req = 1'b1; u_if.wr_alloc_in_id = id; end
    else      begin u_if.rd_alloc_req = 1'b1; u_if.rd_alloc_in_id = id; end
    waited = 0;
    done   = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (side ? u_if.wr_alloc_gnt : u_if.rd_alloc_gnt) done = 1'b1;
      else begin
        waited++;
        if (waited > 40) begin
          chk("gnt_timeout", 32'd0, 32'd1);
          done = 1'b1;
        end
      end
    end
    step();
    if (side) u_if.wr_alloc_req = 1'b0;
    else      u_if.rd_alloc_req = 1'b0;
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #2;
    chk("rst_gnt_rd", {31'd0, u_if.rd_alloc_gnt}, 32'd0);
    chk("rst_free", {27'd0, u_if.free_count}, NUM_UIDS);
    chk("rst_full", {31'd0, u_if.tag_map_full}, 32'd0);
    chk("rst_err", {31'd0, u_if.rel_err}, 32'd0);
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    u_if.rd_alloc_req = 0; u_if.rd_alloc_in_id = '0;
    u_if.wr_alloc_req = 0; u_if.wr_alloc_in_id = '0;
    u_if.rd_rel_valid = 0; u_if.rd_rel_uid = '0;
    u_if.wr_rel_valid = 0; u_if.wr_rel_uid = '0;
    u_if.rd_lookup_uid = '0; u_if.wr_lookup_uid = '0;
    repeat (2) step();
    rst = 1'b0;
    step();

    // 1: reset state and zero-latency first grant
    @(negedge clk);
    chk("init_free", {27'd0, u_if.free_count}, 16);
    chk("init_full", {31'd0, u_if.tag_map_full}, 0);
    chk("init_err", {31'd0, u_if.rel_err}, 0);
    chk("init_lookup", {28'd0, u_if.rd_lookup_id}, 0);
    step();
    request(REQ_RD, 4'h9, 4'd0, w);
    chk("t1_latency", w, 0);
    @(negedge clk);
    chk("t1_free", {27'd0, u_if.free_count}, 15);
    chk("t1_lookup", {28'd0, u_if.rd_lookup_id}, 4'h9);

    // 2: both sides requesting every cycle alternate starting with read
    step();
    pulse_reset();
    u_if.rd_alloc_req = 1'b1;
    u_if.wr_alloc_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      u_if.rd_alloc_in_id = uid_t'(k + 1);
      u_if.wr_alloc_in_id = uid_t'(k + 8);
      exp_q.push_back({k[0], uid_t'(k)});
      @(negedge clk);
      step();
    end
    u_if.rd_alloc_req = 1'b0;
    u_if.wr_alloc_req = 1'b0;
    u_if.rd_lookup_uid = 4'd1;
    u_if.wr_lookup_uid = 4'd2;
    @(negedge clk);
    chk("t2_free", {27'd0, u_if.free_count}, 12);
    chk("t2_lookup1", {28'd0, u_if.rd_lookup_id}, 4'd9);
    chk("t2_lookup2", {28'd0, u_if.wr_lookup_id}, 4'd3);
    step();

    // 3: exhaust the pool, then a release unblocks a held request
    for (int i = 4; i < 16; i++) request(REQ_RD, uid_t'(i), uid_t'(i), w);
    u_if.wr_alloc_req = 1'b1;
    u_if.wr_alloc_in_id = 4'hE;
    exp_q.push_back({1'b1, 4'd5});
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("t3_full", {31'd0, u_if.tag_map_full}, 1);
      chk("t3_nogrant", {31'd0, u_if.wr_alloc_gnt}, 0);
      step();
    end
    u_if.rd_rel_valid = 1'b1;
    u_if.rd_rel_uid = 4'd5;
    u_if.rd_lookup_uid = 4'd5;
    @(negedge clk);
    chk("t3_rel_cycle_gnt", {31'd0, u_if.wr_alloc_gnt}, 0);
    chk("t3_rel_lookup", {28'd0, u_if.rd_lookup_id}, 4'd5);
    step();
    u_if.rd_rel_valid = 1'b0;
    @(negedge clk);
    chk("t3_notfull", {31'd0, u_if.tag_map_full}, 0);
    chk("t3_gnt", {31'd0, u_if.wr_alloc_gnt}, 1);
    step();
    u_if.wr_alloc_req = 1'b0;
    u_if.wr_lookup_uid = 4'd5;
    @(negedge clk);
    chk("t3_refull", {31'd0, u_if.tag_map_full}, 1);
    chk("t3_lookup", {28'd0, u_if.wr_lookup_id}, 4'hE);
    step();

    // 4: two releases alongside a grant
    u_if.rd_rel_valid = 1'b1; u_if.rd_rel_uid = 4'd10;
    step();
    u_if.rd_rel_uid = 4'd2;
    u_if.wr_rel_valid = 1'b1; u_if.wr_rel_uid = 4'd7;
    u_if.wr_alloc_req = 1'b1; u_if.wr_alloc_in_id = 4'h3;
    exp_q.push_back({1'b1, 4'd10});
    @(negedge clk);
    chk("t4_free_before", {27'd0, u_if.free_count}, 1);
    step();
    u_if.rd_rel_valid = 1'b0; u_if.wr_rel_valid = 1'b0; u_if.wr_alloc_req = 1'b0;
    @(negedge clk);
    chk("t4_free_after", {27'd0, u_if.free_count}, 2);
    step();
    request(REQ_RD, 4'h6, 4'd2, w);
    request(REQ_WR, 4'h7, 4'd7, w);
    @(negedge clk);
    chk("t4_free_end", {27'd0, u_if.free_count}, 0);
    chk("t4_err", {31'd0, u_if.rel_err}, 0);
    step();

    // 5: bad releases set the sticky error without touching the count
    u_if.rd_rel_valid = 1'b1; u_if.rd_rel_uid = 4'd12;
    step();
    u_if.rd_rel_valid = 1'b0;
    @(negedge clk);
    chk("t5_good_rel_err", {31'd0, u_if.rel_err}, 0);
    chk("t5_good_rel_free", {27'd0, u_if.free_count}, 1);
    step();
    u_if.rd_rel_valid = 1'b1;
    step();
    u_if.rd_rel_valid = 1'b0;
    @(negedge clk);
    chk("t5_bad_rel_err", {31'd0, u_if.rel_err}, 1);
    chk("t5_bad_rel_free", {27'd0, u_if.free_count}, 1);
    step();
    u_if.rd_rel_valid = 1'b1; u_if.rd_rel_uid = 4'd3;
    u_if.wr_rel_valid = 1'b1; u_if.wr_rel_uid = 4'd3;
    step();
    u_if.rd_rel_valid = 1'b0; u_if.wr_rel_valid = 1'b0;
    @(negedge clk);
    chk("t5_dup_rel_free", {27'd0, u_if.free_count}, 2);
    step();

    // reset in the middle of a pending request
    u_if.rd_alloc_req = 1'b1; u_if.rd_alloc_in_id = 4'hB;
    exp_q.push_back({1'b0, 4'd3});
    @(negedge clk);
    step();
    exp_q.delete();
    #1 rst = 1'b1;
    #2;
    chk("t5_rst_gnt", {31'd0, u_if.rd_alloc_gnt}, 0);
    chk("t5_rst_free", {27'd0, u_if.free_count}, 16);
    chk("t5_rst_full", {31'd0, u_if.tag_map_full}, 0);
    chk("t5_rst_err", {31'd0, u_if.rel_err}, 0);
    u_if.rd_alloc_req = 1'b0;
    u_if.rd_lookup_uid = 4'd0;
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("t5_table_clear", {28'd0, u_if.rd_lookup_id}, 0);
    step();
    request(REQ_RD, 4'h4, 4'd0, w);
    chk("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uid_tag_allocator.md
Name: uid_tag_allocator

Overview:
Shared unique-ID (UID) resource for the read (AR) and write (AW) ID-ordering units. Keeps a free pool of NUM_UIDS tags and a UID-to-original-ID table. Arbitrates allocation requests from the two ordering units round-robin and grants at most one UID per cycle. Frees tags on release from the R-last and B response paths, and serves original-ID lookups so responses can be restored to the master's ID.

Parameters:
ID_WIDTH, 4, width of original ID and of UID
NUM_UIDS, 2**ID_WIDTH, number of tags in the pool; must be ≤ 2**ID_WIDTH and ≥ 2
CNT_WIDTH, $clog2(NUM_UIDS+1), width of the free counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
rd_alloc_req  in  1  AR ordering unit requests a UID
rd_alloc_in_id  in  ID_WIDTH  original ARID to store
rd_alloc_gnt  out  1  grant to the AR unit; UID valid this cycle
rd_unique_id  out  ID_WIDTH  granted UID (valid only when rd_alloc_gnt = 1)
wr_alloc_req  in  1  AW ordering unit requests a UID
wr_alloc_in_id  in  ID_WIDTH  original AWID
wr_alloc_gnt  out  1  grant to the AW unit
wr_unique_id  out  ID_WIDTH  granted UID
rd_rel_valid  in  1  R-last accepted; release rd_rel_uid
rd_rel_uid  in  ID_WIDTH  UID to free
wr_rel_valid  in  1  B accepted; release wr_rel_uid
wr_rel_uid  in  ID_WIDTH  UID to free
rd_lookup_uid  in  ID_WIDTH  UID from the R channel
rd_lookup_id  out  ID_WIDTH  stored original ID (combinational)
wr_lookup_uid  in  ID_WIDTH  UID from the B channel
wr_lookup_id  out  ID_WIDTH  stored original ID (combinational)
tag_map_full  out  1  no free UID (registered)
free_count  out  CNT_WIDTH  number of free UIDs (registered)
rel_err  out  1  sticky flag: release of an unallocated or out-of-range UID

Behaviour:
Reset:
- All UIDs free. free_count = NUM_UIDS. tag_map_full = 0. rel_err = 0.
- Round-robin pointer = read side. Table contents = 0.
- Reset mid-operation discards all allocations; no grant is issued while rst = 1.

State:
- used bitmap [NUM_UIDS]
- orig-ID table [NUM_UIDS][ID_WIDTH]
- free_count
- rr_ptr, 1 bit: 0 = read side has priority, 1 = write side
- rel_err

Grant (combinational, 0-cycle latency):
- sel_uid = lowest-index UID whose registered used bit is 0.
- Grant is possible only if free_count ≠ 0.
- Only one requester is active → grant it. Both active → grant the rr_ptr side only; the other requester is held off.
- The requester holds req until it sees gnt. gnt is asserted for exactly the cycle in which the UID is consumed.
- Both *_unique_id outputs drive sel_uid. The ungranted side's value is don't-care.
- *_alloc_gnt is never asserted while tag_map_full = 1.

On a grant edge:
- used[sel_uid] <= 1
- table[sel_uid] <= the granted side's in_id
- rr_ptr <= opposite of the granted side
- rr_ptr is unchanged when no grant occurs.

Release:
- A release with valid and used[uid] = 1 clears used[uid] at the edge.
- A release of an unused UID, or of a UID ≥ NUM_UIDS, is ignored and sets rel_err (sticky until rst).
- Both releases in the same cycle are allowed.
- If both name the same UID, it frees once and rel_err is set.
- A UID released in cycle N is not grantable before cycle N+1, because grant uses the registered bitmap. Release and grant of different UIDs in the same cycle both take effect.

Counter:
- free_count_next = free_count + (#valid releases) − grant.
- Never exceeds NUM_UIDS and never underflows.
- tag_map_full = (free_count == 0), registered alongside the count.

Lookup:
- Pure read of the table, so it returns the ID written at allocation.
- Lookup of a UID being released in the same cycle returns the still-stored value.

Decomposition:
- Shared package `rob_pkg`:
  - typedef `uid_t` = logic [ID_WIDTH-1:0]
  - localparam NUM_UIDS
  - requester enum {REQ_RD, REQ_WR}
- One sub-module: `uid_free_pick`. It is a parameterised lowest-index-zero finder over the used bitmap and outputs found and index.
- The round-robin, table and counter logic stay in `uid_tag_allocator`.

Test Plan:
1. Reset release, then rd_alloc_req=1, rd_alloc_in_id=4'h9 → rd_alloc_gnt=1, rd_unique_id=0 in the same cycle. Next cycle free_count=15 and rd_lookup_uid=0 returns 9.
2. rd and wr request together for 4 cycles (with each ordering unit's req de-asserted the cycle after its grant, then re-asserted) → grants alternate RD, WR, RD, WR with UIDs 0, 1, 2, 3. rr_ptr flips on each grant.
3. Allocate all 16 UIDs → tag_map_full=1 and no gnt despite an active req. Then rd_rel_uid=5 → the next cycle has tag_map_full=0, and a pending request is granted UID 5 one cycle after the release.
4. rd_rel and wr_rel of UIDs 2 and 7 in the same cycle as a wr grant → free_count changes by +2−1. Each of UIDs 2 and 7 is reusable one cycle later.
5. Release an unallocated UID 12 → rel_err=1 and free_count unchanged. Assert rst mid-traffic → all outputs return to reset values, free_count=16, rel_err=0.
